// File: rtl/spi_pkg.sv
// Shared SPI read-capture constants and FSM state type, used by the RTL and the stimulus master.
package spi_pkg;

  // Command opcodes seen on spi_sdo
  localparam logic [7:0] OP_READ_REG  = 8'd7;
  localparam logic [7:0] OP_WRITE_REG = 8'd1;
  localparam logic [7:0] OP_READ_MEM  = 8'd11;

  // Phase lengths in SPI bits
  localparam int CMD_BITS       = 8;
  localparam int ADDR_BITS      = 32;
  localparam int DATA_BITS      = 32;
  localparam int REG_WDATA_BITS = 8;

  // Bit counter width; wide enough for any dummy length up to 255
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    WDATA,
    RDATA
  } state_t;

endpackage

// File: rtl/spi_read_capture_if.sv
// SPI snoop lines plus the read-word handshake of the capture block.
interface spi_read_capture_if;
  logic        spi_sclk;
  logic        spi_cs;
  logic        spi_sdo;
  logic        spi_sdi;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_is_reg;
  logic        rd_ready;

  // Stimulus side: drives the SPI lines and consumes captured words
  modport master (
    output spi_sclk, spi_cs, spi_sdo, spi_sdi, rd_ready,
    input  rd_valid, rd_data, rd_is_reg
  );

  // Capture side: snoops the SPI lines and presents captured words
  modport slave (
    input  spi_sclk, spi_cs, spi_sdo, spi_sdi, rd_ready,
    output rd_valid, rd_data, rd_is_reg
  );
endinterface

// File: rtl/spi_read_capture_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and simultaneous push/pop, also when full.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push & (~full | do_pop);
  assign level   = count;
  // Head reads as zero while empty so the outputs are clean out of reset
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array, written only on an accepted push
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spi_read_capture.sv
// Snoops an SPI bus, decodes commands and captures read-data words into a FIFO.
module spi_read_capture
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DUMMY_MEM  = 34,
  parameter int DUMMY_REG  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  spi_read_capture_if.slave             bus,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err
);
  state_t      state;
  cnt_t        cnt;
  logic        sclk_q;
  logic        cs_q;
  logic [6:0]  cmd_sh;
  logic [31:0] word_sh;
  logic        is_reg;
  logic        mem_rd;
  logic        push;
  logic        fifo_full;
  logic        fifo_empty;
  logic [32:0] head;
  logic        sclk_rise;
  logic        cs_fall;
  logic        last_bit;
  logic        pop;
  logic [7:0]  opcode;

  assign sclk_rise = ~sclk_q & bus.spi_sclk;
  assign cs_fall   = cs_q & ~bus.spi_cs;
  assign last_bit  = (cnt == cnt_t'(1));
  assign opcode    = {cmd_sh, bus.spi_sdo};
  assign pop       = bus.rd_valid & bus.rd_ready;

  // Edge detection, phase sequencing and read-word assembly
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      cmd_sh    <= '0;
      word_sh   <= '0;
      is_reg    <= 1'b0;
      mem_rd    <= 1'b0;
      push      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_q <= bus.spi_sclk;
      cs_q   <= bus.spi_cs;
      push   <= 1'b0;
      if (state != IDLE && bus.spi_cs) begin
        // Frame closed: clean only on a command boundary with no bits taken
        state <= IDLE;
        cnt   <= '0;
        if (!(state == CMD && cnt == cnt_t'(CMD_BITS))) frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state <= CMD;
              cnt   <= cnt_t'(CMD_BITS);
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_sh <= {cmd_sh[5:0], bus.spi_sdo};
              cnt    <= cnt - 1'b1;
              if (last_bit) begin
                if (opcode == OP_READ_REG) begin
                  is_reg <= 1'b1;
                  if (DUMMY_REG == 0) begin
                    state <= RDATA;
                    cnt   <= cnt_t'(DATA_BITS);
                  end else begin
                    state <= DUMMY;
                    cnt   <= cnt_t'(DUMMY_REG);
                  end
                end else if (opcode == OP_WRITE_REG) begin
                  state <= WDATA;
                  cnt   <= cnt_t'(REG_WDATA_BITS);
                end else begin
                  state  <= ADDR;
                  cnt    <= cnt_t'(ADDR_BITS);
                  is_reg <= 1'b0;
                  mem_rd <= (opcode == OP_READ_MEM);
                end
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              cnt <= cnt - 1'b1;
              if (last_bit) begin
                if (!mem_rd) begin
                  state <= WDATA;
                  cnt   <= cnt_t'(DATA_BITS);
                end else if (DUMMY_MEM == 0) begin
                  state <= RDATA;
                  cnt   <= cnt_t'(DATA_BITS);
                end else begin
                  state <= DUMMY;
                  cnt   <= cnt_t'(DUMMY_MEM);
                end
              end
            end
          end
          DUMMY: begin
            if (sclk_rise) begin
              cnt <= cnt - 1'b1;
              if (last_bit) begin
                state <= RDATA;
                cnt   <= cnt_t'(DATA_BITS);
              end
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              cnt <= cnt - 1'b1;
              if (last_bit) begin
                state <= CMD;
                cnt   <= cnt_t'(CMD_BITS);
              end
            end
          end
          RDATA: begin
            if (sclk_rise) begin
              word_sh <= {word_sh[30:0], bus.spi_sdi};
              cnt     <= cnt - 1'b1;
              if (last_bit) begin
                // word_sh and is_reg stay stable next cycle, when the push lands
                push  <= 1'b1;
                state <= CMD;
                cnt   <= cnt_t'(CMD_BITS);
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Sticky record of a completed word that found the FIFO full with no pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           overflow <= 1'b0;
    else if (push && fifo_full && !pop)    overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .din    ({word_sh, is_reg}),
    .pop    (bus.rd_ready),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  assign bus.rd_valid  = ~fifo_empty;
  assign bus.rd_data   = head[32:1];
  assign bus.rd_is_reg = head[0];
endmodule

// File: tb/tb_spi_read_capture.sv
// Self-checking bench: an SPI stimulus master plus a queue-based model of captured read words.
module tb_spi_read_capture;
  import spi_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int DUMMY_MEM  = 34;
  localparam int DUMMY_REG  = 1;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic overflow;
  logic frame_err;

  spi_read_capture_if bus();

  spi_read_capture #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DUMMY_MEM  (DUMMY_MEM),
    .DUMMY_REG  (DUMMY_REG)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .bus       (bus),
    .level     (level),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: words the DUT should hold, oldest first, as {word, is_reg}
  logic [32:0] exp_q[$];
  bit exp_ovf  = 1'b0;
  bit exp_ferr = 1'b0;

  // A completed read lands in the buffer unless it is full; a same-cycle pop makes room
  function automatic void model_capture(input logic [31:0] w, input bit r, input bit popped);
    logic [32:0] dropped;
    if (popped && exp_q.size() > 0) dropped = exp_q.pop_front();
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({w, r});
    else exp_ovf = 1'b1;
  endfunction

  // ---------------- stimulus master ----------------
  task automatic spi_bit(input logic sdo, input logic sdi, input bit pop_now);
    @(negedge clk_i);
    bus.spi_sclk = 1'b0;
    bus.spi_sdo  = sdo;
    bus.spi_sdi  = sdi;
    @(negedge clk_i);
    @(negedge clk_i);
    bus.spi_sclk = 1'b1;
    @(negedge clk_i);
    if (pop_now) begin
      bus.rd_ready = 1'b1;
      @(negedge clk_i);
      bus.rd_ready = 1'b0;
    end
  endtask

  task automatic send_sdo(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i], 1'($urandom), 1'b0);
  endtask

  task automatic send_sdi(input logic [31:0] v, input int n, input bit pop_last);
    for (int i = n - 1; i >= 0; i--) spi_bit(1'($urandom), v[i], pop_last && (i == 0));
  endtask

  task automatic send_dummy(input int n);
    for (int i = 0; i < n; i++) spi_bit(1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic frame_start;
    @(negedge clk_i);
    bus.spi_sclk = 1'b0;
    bus.spi_cs   = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic frame_end;
    @(negedge clk_i);
    bus.spi_sclk = 1'b0;
    @(negedge clk_i);
    bus.spi_cs = 1'b1;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic pop_one;
    @(negedge clk_i);
    bus.rd_ready = 1'b1;
    @(negedge clk_i);
    bus.rd_ready = 1'b0;
  endtask

  task automatic xact_read_mem(input logic [31:0] addr, input logic [31:0] data, input bit pop_last);
    send_sdo(32'(OP_READ_MEM), CMD_BITS);
    send_sdo(addr, ADDR_BITS);
    send_dummy(DUMMY_MEM);
    send_sdi(data, DATA_BITS, pop_last);
    model_capture(data, 1'b0, pop_last);
  endtask

  task automatic xact_read_reg(input logic [31:0] data, input bit pop_last);
    send_sdo(32'(OP_READ_REG), CMD_BITS);
    send_dummy(DUMMY_REG);
    send_sdi(data, DATA_BITS, pop_last);
    model_capture(data, 1'b1, pop_last);
  endtask

  task automatic xact_write_reg(input logic [7:0] data);
    send_sdo(32'(OP_WRITE_REG), CMD_BITS);
    send_sdo(32'(data), REG_WDATA_BITS);
  endtask

  task automatic xact_write_mem(input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] op;
    do op = 8'($urandom);
    while (op == OP_READ_REG || op == OP_WRITE_REG || op == OP_READ_MEM);
    send_sdo(32'(op), CMD_BITS);
    send_sdo(addr, ADDR_BITS);
    send_sdo(data, DATA_BITS);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (level !== '0) begin n_bad++; $display("FAIL reset_level: got %0d, need 0", level); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b, need 0", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h, need 00000000", bus.rd_data); end
    n_cmp++; if (bus.rd_is_reg !== 1'b0) begin n_bad++; $display("FAIL reset_rd_is_reg: got %b, need 0", bus.rd_is_reg); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b, need 0", overflow); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b, need 0", frame_err); end
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    // Pop on an empty buffer must be ignored
    bus.rd_ready = 1'b1;
    repeat (3) @(negedge clk_i);
    bus.rd_ready = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (level !== '0 || bus.rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL pop_empty: got level=%0d valid=%b, need level=0 valid=0", level, bus.rd_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_read_mem;
    logic [32:0] exp_head;
    frame_start();
    xact_read_mem(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    frame_end();
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL read_mem_level: got %0d, need 1", level); end
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hDEAD_BEEF || bus.rd_is_reg !== 1'b0) begin
      n_bad++; $display("FAIL read_mem_head: got valid=%b data=%h reg=%b, need valid=1 data=deadbeef reg=0",
                        bus.rd_valid, bus.rd_data, bus.rd_is_reg);
    end
    exp_head = exp_q.pop_front();
    pop_one();
    n_cmp++; if (level !== '0) begin n_bad++; $display("FAIL read_mem_pop_level: got %0d, need 0", level); end
    // A few randomised single read-mem frames
    for (int k = 0; k < 3; k++) begin
      frame_start();
      xact_read_mem($urandom, $urandom, 1'b0);
      frame_end();
      exp_head = exp_q.pop_front();
      n_cmp++; if (bus.rd_valid !== 1'b1 || {bus.rd_data, bus.rd_is_reg} !== exp_head) begin
        n_bad++; $display("FAIL read_mem_rand_head: got valid=%b data=%h reg=%b, need data=%h reg=%b",
                          bus.rd_valid, bus.rd_data, bus.rd_is_reg, exp_head[32:1], exp_head[0]);
      end
      pop_one();
      $display("read_mem random %0d data=%h", k, exp_head[32:1]);
    end
    $display("test_read_mem done");
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp_head;
    frame_start();
    xact_read_reg(32'h1234_5678, 1'b0);
    xact_write_mem($urandom, $urandom);
    xact_read_reg(32'h0000_A5A5, 1'b0);
    frame_end();
    n_cmp++; if (level !== 4'd2) begin n_bad++; $display("FAIL b2b_level: got %0d, need 2", level); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL b2b_clean_close: got frame_err=%b, need 0", frame_err); end
    while (exp_q.size() > 0) begin
      exp_head = exp_q.pop_front();
      n_cmp++; if (bus.rd_valid !== 1'b1 || {bus.rd_data, bus.rd_is_reg} !== exp_head) begin
        n_bad++; $display("FAIL b2b_head: got valid=%b data=%h reg=%b, need data=%h reg=%b",
                          bus.rd_valid, bus.rd_data, bus.rd_is_reg, exp_head[32:1], exp_head[0]);
      end
      pop_one();
    end
    n_cmp++; if (level !== '0) begin n_bad++; $display("FAIL b2b_drained: got %0d, need 0", level); end
    $display("test_back_to_back done");
  endtask

  task automatic test_frame_err;
    logic [32:0] exp_head;
    frame_start();
    send_sdo(32'(OP_READ_MEM), CMD_BITS);
    send_sdo($urandom, ADDR_BITS);
    send_dummy(DUMMY_MEM);
    send_sdi($urandom, 12, 1'b0);
    frame_end();
    exp_ferr = 1'b1;
    n_cmp++; if (level !== '0 || bus.rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL ferr_no_push: got level=%0d valid=%b, need level=0 valid=0", level, bus.rd_valid);
    end
    n_cmp++; if (frame_err !== exp_ferr) begin n_bad++; $display("FAIL ferr_flag: got %b, need %b", frame_err, exp_ferr); end
    frame_start();
    xact_read_reg($urandom, 1'b0);
    frame_end();
    exp_head = exp_q.pop_front();
    n_cmp++; if (bus.rd_valid !== 1'b1 || {bus.rd_data, bus.rd_is_reg} !== exp_head) begin
      n_bad++; $display("FAIL ferr_next_frame: got valid=%b data=%h reg=%b, need data=%h reg=%b",
                        bus.rd_valid, bus.rd_data, bus.rd_is_reg, exp_head[32:1], exp_head[0]);
    end
    pop_one();
    n_cmp++; if (frame_err !== exp_ferr) begin n_bad++; $display("FAIL ferr_sticky: got %b, need %b", frame_err, exp_ferr); end
    $display("test_frame_err done");
  endtask

  task automatic test_overflow;
    logic [32:0] exp_head;
    frame_start();
    for (int k = 0; k < 9; k++) xact_read_mem($urandom, $urandom, 1'b0);
    frame_end();
    n_cmp++; if (int'(level) != exp_q.size()) begin n_bad++; $display("FAIL ovf_level: got %0d, need %0d", level, exp_q.size()); end
    n_cmp++; if (overflow !== exp_ovf) begin n_bad++; $display("FAIL ovf_flag: got %b, need %b", overflow, exp_ovf); end
    // Tenth word arrives in the same cycle as a pop
    frame_start();
    xact_read_mem($urandom, $urandom, 1'b1);
    frame_end();
    n_cmp++; if (int'(level) != exp_q.size()) begin n_bad++; $display("FAIL ovf_pushpop_level: got %0d, need %0d", level, exp_q.size()); end
    n_cmp++; if (overflow !== exp_ovf) begin n_bad++; $display("FAIL ovf_sticky: got %b, need %b", overflow, exp_ovf); end
    while (exp_q.size() > 0) begin
      exp_head = exp_q.pop_front();
      n_cmp++; if (bus.rd_valid !== 1'b1 || {bus.rd_data, bus.rd_is_reg} !== exp_head) begin
        n_bad++; $display("FAIL ovf_drain_head: got valid=%b data=%h reg=%b, need data=%h reg=%b",
                          bus.rd_valid, bus.rd_data, bus.rd_is_reg, exp_head[32:1], exp_head[0]);
      end
      pop_one();
    end
    n_cmp++; if (level !== '0) begin n_bad++; $display("FAIL ovf_drained: got %0d, need 0", level); end
    $display("test_overflow done");
  endtask

  task automatic test_reset_mid;
    logic [32:0] exp_head;
    frame_start();
    for (int k = 0; k < 3; k++) xact_read_mem($urandom, $urandom, 1'b0);
    frame_end();
    n_cmp++; if (level !== 4'd3) begin n_bad++; $display("FAIL rmid_pre_level: got %0d, need 3", level); end
    frame_start();
    send_sdo(32'(OP_READ_MEM), CMD_BITS);
    send_sdo($urandom, 10);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    n_cmp++; if (level !== '0 || bus.rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_flush: got level=%0d valid=%b, need level=0 valid=0", level, bus.rd_valid);
    end
    n_cmp++; if (overflow !== exp_ovf || frame_err !== exp_ferr) begin
      n_bad++; $display("FAIL rmid_flags: got ovf=%b ferr=%b, need ovf=0 ferr=0", overflow, frame_err);
    end
    bus.spi_sclk = 1'b0;
    bus.spi_cs   = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    frame_start();
    xact_read_mem($urandom, $urandom, 1'b0);
    frame_end();
    exp_head = exp_q.pop_front();
    n_cmp++; if (level !== 4'd1 || {bus.rd_data, bus.rd_is_reg} !== exp_head) begin
      n_bad++; $display("FAIL rmid_after: got level=%0d data=%h reg=%b, need level=1 data=%h reg=%b",
                        level, bus.rd_data, bus.rd_is_reg, exp_head[32:1], exp_head[0]);
    end
    pop_one();
    $display("test_reset_mid done");
  endtask

  task automatic test_full_push_pop;
    logic [32:0] exp_head;
    frame_start();
    for (int k = 0; k < FIFO_DEPTH; k++) xact_read_reg($urandom, 1'b0);
    frame_end();
    n_cmp++; if (int'(level) != exp_q.size() || overflow !== exp_ovf) begin
      n_bad++; $display("FAIL full_fill: got level=%0d ovf=%b, need level=%0d ovf=%b", level, overflow, exp_q.size(), exp_ovf);
    end
    frame_start();
    xact_read_reg($urandom, 1'b1);
    frame_end();
    n_cmp++; if (int'(level) != exp_q.size() || overflow !== exp_ovf) begin
      n_bad++; $display("FAIL full_pushpop: got level=%0d ovf=%b, need level=%0d ovf=%b", level, overflow, exp_q.size(), exp_ovf);
    end
    while (exp_q.size() > 0) begin
      exp_head = exp_q.pop_front();
      n_cmp++; if (bus.rd_valid !== 1'b1 || {bus.rd_data, bus.rd_is_reg} !== exp_head) begin
        n_bad++; $display("FAIL full_drain_head: got valid=%b data=%h reg=%b, need data=%h reg=%b",
                          bus.rd_valid, bus.rd_data, bus.rd_is_reg, exp_head[32:1], exp_head[0]);
      end
      pop_one();
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_random;
    logic [32:0] exp_head;
    int n_xact;
    int n_pop;
    for (int f = 0; f < 6; f++) begin
      frame_start();
      n_xact = $urandom_range(1, 3);
      for (int t = 0; t < n_xact; t++) begin
        case ($urandom_range(0, 3))
          0:       xact_read_mem($urandom, $urandom, 1'b0);
          1:       xact_read_reg($urandom, 1'b0);
          2:       xact_write_reg(8'($urandom));
          default: xact_write_mem($urandom, $urandom);
        endcase
      end
      frame_end();
      n_cmp++; if (int'(level) != exp_q.size()) begin n_bad++; $display("FAIL rand_level: got %0d, need %0d", level, exp_q.size()); end
      n_pop = $urandom_range(0, exp_q.size());
      if (exp_q.size() - n_pop > 4) n_pop = exp_q.size() - 4;
      for (int p = 0; p < n_pop; p++) begin
        exp_head = exp_q.pop_front();
        n_cmp++; if (bus.rd_valid !== 1'b1 || {bus.rd_data, bus.rd_is_reg} !== exp_head) begin
          n_bad++; $display("FAIL rand_head: got valid=%b data=%h reg=%b, need data=%h reg=%b",
                            bus.rd_valid, bus.rd_data, bus.rd_is_reg, exp_head[32:1], exp_head[0]);
        end
        pop_one();
      end
      $display("random frame %0d: %0d transactions, %0d popped, %0d held", f, n_xact, n_pop, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      exp_head = exp_q.pop_front();
      n_cmp++; if (bus.rd_valid !== 1'b1 || {bus.rd_data, bus.rd_is_reg} !== exp_head) begin
        n_bad++; $display("FAIL rand_drain_head: got valid=%b data=%h reg=%b, need data=%h reg=%b",
                          bus.rd_valid, bus.rd_data, bus.rd_is_reg, exp_head[32:1], exp_head[0]);
      end
      pop_one();
    end
    n_cmp++; if (level !== '0 || overflow !== exp_ovf || frame_err !== exp_ferr) begin
      n_bad++; $display("FAIL rand_final: got level=%0d ovf=%b ferr=%b, need level=0 ovf=%b ferr=%b",
                        level, overflow, frame_err, exp_ovf, exp_ferr);
    end
    $display("test_random done");
  endtask

  initial begin
    bus.spi_sclk = 1'b0;
    bus.spi_cs   = 1'b1;
    bus.spi_sdo  = 1'b0;
    bus.spi_sdi  = 1'b0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_read_mem();
    test_back_to_back();
    test_frame_err();
    test_overflow();
    test_reset_mid();
    test_full_push_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Time limit so a stuck run still ends
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "time limit reached");
  end
endmodule
